// File: rtl/seq_detect_ctrl.sv
// seq_detect_ctrl: programmable serial-pattern detector with match counting.
// A start command latches the pattern, length, overlap mode and target count.
// Valid-qualified bits are then scanned, and each match is counted. The block
// finishes in DONE when a non-zero target count is reached.
module seq_detect_ctrl #(
   parameter int PW = 8,
   parameter int CW = 8
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     start,
   input  logic                     abort,
   input  logic [PW-1:0]            cfg_pattern,
   input  logic [$clog2(PW+1)-1:0]  cfg_len,
   input  logic                     cfg_overlap,
   input  logic [CW-1:0]            cfg_target,
   input  logic                     data_valid,
   input  logic                     data,
   output logic                     busy,
   output logic                     match,
   output logic [CW-1:0]            match_count,
   output logic                     done,
   output logic                     cfg_err
);

   localparam int LW = $clog2(PW+1);
   localparam logic [LW-1:0] PW_L = LW'(PW);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t        r_state;
   state_t        w_state_nx;

   logic [PW-1:0] r_win;
   logic [LW-1:0] r_fill;
   logic [PW-1:0] r_pat;
   logic [LW-1:0] r_len;
   logic          r_ovl;
   logic [CW-1:0] r_tgt;
   logic [CW-1:0] r_count;
   logic          r_busy;
   logic          r_match;
   logic          r_done;
   logic          r_cfg_err;

   logic [PW-1:0] w_win_nx;
   logic [LW-1:0] w_fill_nx;
   logic [CW-1:0] w_count_nx;
   logic          w_match_nx;
   logic          w_err_nx;
   logic          w_latch;

   logic          w_len_ok;
   logic [PW-1:0] w_shift;
   logic [LW-1:0] w_fill_inc;
   logic [PW-1:0] w_ones;
   logic [PW-1:0] w_mask;
   logic [CW-1:0] w_count_inc;
   logic          w_hit;

   // Pattern-compare helpers derived from the latched configuration
   always_comb begin
      w_len_ok    = (cfg_len != '0) && (cfg_len <= PW_L);
      w_shift     = PW'({r_win, data});
      w_fill_inc  = (r_fill == PW_L) ? r_fill : r_fill + LW'(1);
      w_ones      = '1;
      w_mask      = ~(w_ones << r_len);
      w_count_inc = (r_count == '1) ? r_count : r_count + CW'(1);
      w_hit       = (w_fill_inc >= r_len) && ((w_shift & w_mask) == (r_pat & w_mask));
   end

   // Next-state and next-output logic; abort takes priority over everything
   always_comb begin
      w_state_nx = r_state;
      w_win_nx   = r_win;
      w_fill_nx  = r_fill;
      w_count_nx = r_count;
      w_match_nx = 1'b0;
      w_err_nx   = 1'b0;
      w_latch    = 1'b0;
      unique case (r_state)
         S_IDLE, S_DONE: begin
            if (abort) begin
               w_state_nx = S_IDLE;
            end else if (start) begin
               if (w_len_ok) begin
                  w_latch    = 1'b1;
                  w_state_nx = S_RUN;
                  w_win_nx   = '0;
                  w_fill_nx  = '0;
                  w_count_nx = '0;
               end else begin
                  w_err_nx = 1'b1;
               end
            end
         end
         S_RUN: begin
            if (abort) begin
               w_state_nx = S_IDLE;
            end else if (data_valid) begin
               w_win_nx  = w_shift;
               w_fill_nx = w_fill_inc;
               if (w_hit) begin
                  w_match_nx = 1'b1;
                  w_count_nx = w_count_inc;
                  if (!r_ovl) begin
                     w_fill_nx = '0;
                  end
                  if ((r_tgt != '0) && (w_count_inc == r_tgt)) begin
                     w_state_nx = S_DONE;
                  end
               end
            end
         end
         default: w_state_nx = S_IDLE;
      endcase
   end

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nx;
      end
   end

   // Datapath, latched configuration and registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_win     <= '0;
         r_fill    <= '0;
         r_pat     <= '0;
         r_len     <= '0;
         r_ovl     <= 1'b0;
         r_tgt     <= '0;
         r_count   <= '0;
         r_busy    <= 1'b0;
         r_match   <= 1'b0;
         r_done    <= 1'b0;
         r_cfg_err <= 1'b0;
      end else begin
         r_win     <= w_win_nx;
         r_fill    <= w_fill_nx;
         r_count   <= w_count_nx;
         r_match   <= w_match_nx;
         r_cfg_err <= w_err_nx;
         r_busy    <= (w_state_nx == S_RUN);
         r_done    <= (w_state_nx == S_DONE);
         if (w_latch) begin
            r_pat <= cfg_pattern;
            r_len <= cfg_len;
            r_ovl <= cfg_overlap;
            r_tgt <= cfg_target;
         end
      end
   end

   assign busy        = r_busy;
   assign match       = r_match;
   assign match_count = r_count;
   assign done        = r_done;
   assign cfg_err     = r_cfg_err;

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// Bench for seq_detect_ctrl: directed scenarios plus random traffic, all
// checked cycle by cycle against a queue-based reference model.
module tb_seq_detect_ctrl;

   localparam int PW = 8;
   localparam int CW = 8;
   localparam int LW = $clog2(PW+1);

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0;
   logic          abort = 1'b0;
   logic [PW-1:0] cfg_pattern = '0;
   logic [LW-1:0] cfg_len = '0;
   logic          cfg_overlap = 1'b0;
   logic [CW-1:0] cfg_target = '0;
   logic          data_valid = 1'b0;
   logic          data = 1'b0;
   logic          busy;
   logic          match;
   logic [CW-1:0] match_count;
   logic          done;
   logic          cfg_err;

   int n_checks = 0;
   int n_errors = 0;

   seq_detect_ctrl #(.PW(PW), .CW(CW)) u_dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .abort       (abort),
      .cfg_pattern (cfg_pattern),
      .cfg_len     (cfg_len),
      .cfg_overlap (cfg_overlap),
      .cfg_target  (cfg_target),
      .data_valid  (data_valid),
      .data        (data),
      .busy        (busy),
      .match       (match),
      .match_count (match_count),
      .done        (done),
      .cfg_err     (cfg_err)
   );

   always #5 clk = ~clk;

   // Reference model: 0 idle, 1 scanning, 2 finished.
   // Keeps the valid bits seen since the window last restarted.
   int            m_st;
   bit            m_q[$];
   int            m_len;
   logic [PW-1:0] m_pat;
   bit            m_ovl;
   int            m_tgt;
   int            m_cnt;
   bit            m_match;
   bit            m_err;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic void model_reset();
      m_st = 0; m_q.delete(); m_len = 0; m_pat = '0; m_ovl = 0;
      m_tgt = 0; m_cnt = 0; m_match = 0; m_err = 0;
   endfunction

   function automatic bit tail_matches();
      if (m_q.size() < m_len) return 0;
      for (int i = 0; i < m_len; i++)
         if (m_q[m_q.size()-1-i] != m_pat[i]) return 0;
      return 1;
   endfunction

   function automatic void model_step();
      m_match = 0;
      m_err   = 0;
      if (abort) begin
         m_st = 0;
      end else if (m_st == 1) begin
         if (data_valid) begin
            m_q.push_back(data);
            if (m_q.size() > PW) void'(m_q.pop_front());
            if (tail_matches()) begin
               m_match = 1;
               if (m_cnt < (1 << CW) - 1) m_cnt++;
               if (!m_ovl) m_q.delete();
               if (m_tgt != 0 && m_cnt == m_tgt) m_st = 2;
            end
         end
      end else if (start) begin
         if (cfg_len >= 1 && cfg_len <= PW) begin
            m_len = int'(cfg_len); m_pat = cfg_pattern; m_ovl = cfg_overlap;
            m_tgt = int'(cfg_target); m_q.delete(); m_cnt = 0; m_st = 1;
         end else begin
            m_err = 1;
         end
      end
   endfunction

   task automatic check_all();
      check("busy",    32'(busy),        32'(m_st == 1));
      check("done",    32'(done),        32'(m_st == 2));
      check("match",   32'(match),       32'(m_match));
      check("count",   32'(match_count), 32'(m_cnt));
      check("cfg_err", 32'(cfg_err),     32'(m_err));
   endtask

   // Inputs are applied at the falling edge; the model advances on the rising edge
   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
      check_all();
      @(negedge clk);
      start = 1'b0;
      abort = 1'b0;
   endtask

   task automatic set_cfg(input logic [PW-1:0] p, input int len, input bit ovl, input int tgt);
      cfg_pattern = p;
      cfg_len     = LW'(len);
      cfg_overlap = ovl;
      cfg_target  = CW'(tgt);
   endtask

   task automatic bit_in(input bit b);
      data_valid = 1'b1;
      data       = b;
      tick();
      data_valid = 1'b0;
   endtask

   task automatic do_start();
      start = 1'b1;
      tick();
   endtask

   task automatic do_abort();
      abort = 1'b1;
      tick();
   endtask

   initial begin
      bit stream[7] = '{1, 0, 1, 0, 1, 0, 1};
      model_reset();

      // Reset state
      #2;
      check_all();
      @(negedge clk);
      rst_n = 1'b1;
      tick();

      // Overlap mode
      set_cfg(8'b1010, 4, 1, 0);
      do_start();
      foreach (stream[i]) bit_in(stream[i]);
      check("ovl_count", 32'(match_count), 32'd2);
      check("ovl_busy",  32'(busy),        32'd1);

      // Non-overlap mode
      do_abort();
      set_cfg(8'b1010, 4, 0, 0);
      do_start();
      foreach (stream[i]) bit_in(stream[i]);
      check("novl_count1", 32'(match_count), 32'd1);
      bit_in(0);
      check("novl_count2", 32'(match_count), 32'd2);

      // Target completion
      do_abort();
      set_cfg(8'b11, 2, 1, 3);
      do_start();
      repeat (4) bit_in(1);
      check("tgt_done",  32'(done), 32'd1);
      check("tgt_busy",  32'(busy), 32'd0);
      bit_in(1);
      check("tgt_count", 32'(match_count), 32'd3);

      // Valid gaps with garbage data; start while running; abort+start together
      set_cfg(8'b101, 3, 1, 0);
      do_start();
      for (int i = 0; i < 5; i++) begin
         data_valid = 1'b0;
         data = 1'($urandom);
         tick();
         bit_in((i % 2) == 0);
      end
      check("gap_count", 32'(match_count), 32'd2);
      set_cfg(8'b1, 1, 1, 1);
      do_start();
      bit_in(1);
      check("run_start_ignored", 32'(match_count), 32'd2);
      start = 1'b1;
      abort = 1'b1;
      tick();
      check("abort_start_busy",  32'(busy),        32'd0);
      check("abort_start_count", 32'(match_count), 32'd2);

      // Illegal configuration
      set_cfg(8'b1, 0, 1, 0);
      do_start();
      check("len0_err", 32'(cfg_err), 32'd1);
      set_cfg(8'b1, PW + 1, 1, 0);
      do_start();
      check("lenbig_err",  32'(cfg_err), 32'd1);
      check("lenbig_busy", 32'(busy),    32'd0);
      tick();

      // Asynchronous reset mid-run
      set_cfg(8'b11, 2, 1, 0);
      do_start();
      repeat (4) bit_in(1);
      check("pre_rst_count", 32'(match_count), 32'd3);
      #2;
      rst_n = 1'b0;
      #1;
      model_reset();
      check("rst_busy",  32'(busy),        32'd0);
      check("rst_count", 32'(match_count), 32'd0);
      check("rst_match", 32'(match),       32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      do_start();
      repeat (3) bit_in(1);
      check("post_rst_count", 32'(match_count), 32'd2);

      // Counter saturation
      do_abort();
      set_cfg(8'b1, 1, 1, 0);
      do_start();
      repeat (300) bit_in(1);
      check("sat_count", 32'(match_count), 32'd255);

      // Random traffic
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(99) < 4) begin
            set_cfg(PW'($urandom), int'($urandom_range(PW + 1)), 1'($urandom),
                    int'($urandom_range(6)));
            start = 1'b1;
         end
         abort      = ($urandom_range(99) < 2);
         data_valid = ($urandom_range(99) < 70);
         data       = 1'($urandom);
         tick();
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
